// File: rtl/text_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : text_writer_if
// Description : Groups the byte-stream handshake (in_data/in_valid/in_ready)
//               and the character RAM write port (wr_en/wr_addr/wr_data)
//               used by text_writer.
//               slave  : the text_writer side (consumes bytes, drives RAM).
//               master : the producer / RAM side (drives bytes, observes RAM).
// Revision    : 1.0 - initial release
// ============================================================================
interface text_writer_if #(
    parameter int AW = 12
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface
`default_nettype wire

// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_writer
// Description : Text cursor engine feeding the character RAM write port.
//               Printable ASCII is written at the cursor; CR, LF, BS and FF
//               move the cursor; row advances and form feeds launch a clear
//               sequencer that fills a row / the whole screen with spaces.
// Ports       : clk      - system clock, rising edge
//               rstn     - asynchronous active-low reset
//               bus      - text_writer_if.slave (byte stream + RAM write)
//               cur_col  - cursor column 0..COLS-1
//               cur_row  - cursor row 0..ROWS-1
//               busy     - clear in progress (inverse of in_ready)
// Revision    : 1.0 - initial release
// ============================================================================
module text_writer #(
    parameter int COLS           = 80,
    parameter int ROWS           = 30,
    parameter int AW             = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    text_writer_if.slave     bus,
    output logic [6:0]       cur_col,
    output logic [4:0]       cur_row,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam state_t     c_RESET_STATE = CLEAR_ON_RESET ? CLR_ALL : IDLE;
    localparam logic [AW:0] c_COLS_W     = (AW+1)'(COLS);
    localparam logic [AW:0] c_TOTAL_W    = (AW+1)'(COLS * ROWS);
    localparam logic [7:0]  c_SPACE      = 8'h20;

    state_t        r_state,    w_state;
    logic [6:0]    r_col,      w_col;
    logic [4:0]    r_row,      w_row;
    logic [AW-1:0] r_row_base, w_row_base;
    // Clear sequencer: r_clr_addr is the next address to write, r_clr_end is
    // one past the last. One extra bit so a full screen of 2^AW fits.
    logic [AW:0]   r_clr_addr, w_clr_addr;
    logic [AW:0]   r_clr_end,  w_clr_end;
    logic          r_wr_en,    w_wr_en;
    logic [AW-1:0] r_wr_addr,  w_wr_addr;
    logic [7:0]    r_wr_data,  w_wr_data;

    logic          w_accept;
    logic          w_printable;
    logic          w_last_row;
    logic [4:0]    w_next_row;
    logic [AW-1:0] w_next_base;
    logic [AW-1:0] w_char_addr;

    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
    assign w_last_row  = (r_row == 5'(ROWS - 1));
    assign w_next_row  = w_last_row ? 5'd0 : r_row + 5'd1;
    // Row base tracks cur_row*COLS incrementally, so no multiplier is needed.
    assign w_next_base = w_last_row ? '0 : r_row_base + AW'(COLS);
    assign w_char_addr = r_row_base + AW'(r_col);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_RESET_STATE;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_clr_addr <= '0;
            r_clr_end  <= c_TOTAL_W;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_col      <= w_col;
            r_row      <= w_row;
            r_row_base <= w_row_base;
            r_clr_addr <= w_clr_addr;
            r_clr_end  <= w_clr_end;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_col      = r_col;
        w_row      = r_row;
        w_row_base = r_row_base;
        w_clr_addr = r_clr_addr;
        w_clr_end  = r_clr_end;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_char_addr;
                        w_wr_data = bus.in_data;
                        if (r_col < 7'(COLS - 1)) begin
                            w_col = r_col + 7'd1;
                        end else begin
                            // Character write occupies this cycle's write
                            // slot; the whole new row is cleared afterwards.
                            w_col      = '0;
                            w_row      = w_next_row;
                            w_row_base = w_next_base;
                            w_clr_addr = {1'b0, w_next_base};
                            w_clr_end  = {1'b0, w_next_base} + c_COLS_W;
                            w_state    = CLR_ROW;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0D: w_col = '0;
                            8'h0A: begin
                                // The first clear write is issued straight
                                // from the accept so the clear starts at N+1.
                                w_col      = '0;
                                w_row      = w_next_row;
                                w_row_base = w_next_base;
                                w_wr_en    = 1'b1;
                                w_wr_addr  = w_next_base;
                                w_wr_data  = c_SPACE;
                                w_clr_addr = {1'b0, w_next_base} + (AW+1)'(1);
                                w_clr_end  = {1'b0, w_next_base} + c_COLS_W;
                                w_state    = CLR_ROW;
                            end
                            8'h08: begin
                                if (r_col != 7'd0) begin
                                    w_col = r_col - 7'd1;
                                end
                            end
                            8'h0C: begin
                                w_col      = '0;
                                w_row      = '0;
                                w_row_base = '0;
                                w_wr_en    = 1'b1;
                                w_wr_addr  = '0;
                                w_wr_data  = c_SPACE;
                                w_clr_addr = (AW+1)'(1);
                                w_clr_end  = c_TOTAL_W;
                                w_state    = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLR_ROW, CLR_ALL: begin
                if (r_clr_addr == r_clr_end) begin
                    w_state = IDLE;
                end else begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = r_clr_addr[AW-1:0];
                    w_wr_data  = c_SPACE;
                    w_clr_addr = r_clr_addr + (AW+1)'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.in_ready = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign cur_col      = r_col;
    assign cur_row      = r_row;

endmodule
`default_nettype wire

// File: tb/tb_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_writer
// Description : Self-checking bench for text_writer. A cycle-stamped model of
//               expected RAM writes, ready windows and cursor position is
//               compared against the DUT on every falling clock edge, with a
//               few literal expectations pinning key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_writer;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int TOTAL = COLS * ROWS;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    text_writer_if #(.AW(AW)) bus ();

    text_writer #(
        .COLS(COLS), .ROWS(ROWS), .AW(AW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  m_col, m_row, busy_until;
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic push_clear(input int start, input int base, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back('{start + i, base + i, 32'h20});
        busy_until = start + len - 1;
    endtask

    task automatic advance_row(input int start);
        m_row = (m_row + 1) % ROWS;
        push_clear(start, m_row * COLS, COLS);
    endtask

    task automatic model_accept(input logic [7:0] b, input int n);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back('{n + 1, m_row * COLS + m_col, int'(b)});
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                advance_row(n + 2);
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            advance_row(n + 1);
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_clear(n + 1, 0, TOTAL);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_col      = 0;
        m_row      = 0;
        busy_until = 32'h7fff_ffff;
    endtask

    // Called just after a rising edge: the clear starts on the next edge.
    task automatic model_release();
        push_clear(cyc + 1, 0, TOTAL);
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_wr_en",    32'(bus.wr_en),    0);
                check("rst_wr_addr",  32'(bus.wr_addr),  0);
                check("rst_wr_data",  32'(bus.wr_data),  0);
                check("rst_cur_col",  32'(cur_col),      0);
                check("rst_cur_row",  32'(cur_row),      0);
                check("rst_in_ready", 32'(bus.in_ready), 0);
                check("rst_busy",     32'(busy),         1);
            end else begin
                bit exp_we;
                bit exp_rdy;
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
                exp_we  = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                exp_rdy = (cyc > busy_until);
                check("wr_en", 32'(bus.wr_en), 32'(exp_we));
                if (exp_we) begin
                    check("wr_addr", 32'(bus.wr_addr), exp_q[0].addr);
                    check("wr_data", 32'(bus.wr_data), exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
                check("busy",     32'(busy),         32'(!exp_rdy));
                check("cur_col",  32'(cur_col),      m_col);
                check("cur_row",  32'(cur_row),      m_row);
                if (bus.in_valid && exp_rdy) model_accept(bus.in_data, cyc);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after a rising edge; returns likewise.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            $display("FAIL send_timeout: in_ready stuck at 0 expected 1 (cycle %0d)", cyc);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            $display("FAIL idle_timeout: in_ready stuck at 0 expected 1 (cycle %0d)", cyc);
            $fatal(1);
        end
        align();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        fork
            monitor();
        join_none

        // Reset and power-up clear
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_release();
        wait_idle();
        check("pin_reset_col", 32'(cur_col), 0);
        check("pin_reset_row", 32'(cur_row), 0);

        // "AB" back-to-back
        send_byte(8'h41);
        send_byte(8'h42);
        @(negedge clk);
        check("pin_ab_col", 32'(cur_col), 2);
        check("pin_ab_model_col", m_col, 2);
        align();

        // 80 'x' from (0,0): wraps to row 1 and clears it
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte(8'h78);
        @(negedge clk);
        check("pin_x_last_addr", 32'(bus.wr_addr), 79);
        check("pin_x_last_data", 32'(bus.wr_data), 32'h78);
        check("pin_x_row",       32'(cur_row),     1);
        wait_idle();

        // Reach (5,29), then LF wraps to row 0 and clears it
        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'h2E);
        @(negedge clk);
        check("pin_529_col", 32'(cur_col), 5);
        check("pin_529_row", 32'(cur_row), 29);
        align();
        send_byte(8'h0A);
        @(negedge clk);
        check("pin_lf_wr_en", 32'(bus.wr_en),   1);
        check("pin_lf_addr",  32'(bus.wr_addr), 0);
        check("pin_lf_row",   32'(cur_row),     0);
        wait_idle();
        send_byte(8'h08);
        @(negedge clk);
        check("pin_bs_col", 32'(cur_col), 0);
        align();

        // Reach (10,3), CR then 'Z'
        for (int i = 0; i < 3; i++) send_byte(8'h0A);
        for (int i = 0; i < 10; i++) send_byte(8'h79);
        send_byte(8'h0D);
        send_byte(8'h5A);
        @(negedge clk);
        check("pin_z_addr", 32'(bus.wr_addr), 240);
        check("pin_z_data", 32'(bus.wr_data), 32'h5A);
        check("pin_z_col",  32'(cur_col),     1);
        align();
        send_byte(8'h07);              // ignored code
        send_byte(8'h0C);
        wait_idle();
        check("pin_ff_col", 32'(cur_col), 0);
        check("pin_ff_row", 32'(cur_row), 0);

        // Reset during write 100 of a full clear
        send_byte(8'h0C);              // write 1 visible in this cycle
        repeat (99) @(posedge clk);
        #3;
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        check("pin_midrst_wr_en", 32'(bus.wr_en), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_release();
        @(negedge clk);
        @(negedge clk);
        check("pin_restart_wr_en", 32'(bus.wr_en),   1);
        check("pin_restart_addr",  32'(bus.wr_addr), 0);
        wait_idle();
        send_byte(8'h51);
        @(negedge clk);
        check("pin_after_q_addr", 32'(bus.wr_addr), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
